// File: rtl/pe_packetizer.sv
// -----------------------------------------------------------------------------
// pe_packetizer
//
// Purpose:
//   Sits between a PE and the bus interface stage. Accepts one wide PE word on
//   a valid/ready handshake and splits it into NUM_FLITS payload slices. Each
//   slice goes out as a bus packet {valid, dest addr, payload} on pkt_o,
//   least-significant slice first. The interface's resend (FIFO full) is
//   treated as backpressure: while it is high no flit is presented (pkt_o is
//   all zeros) and the current flit is held, so nothing is written into a full
//   FIFO and lost.
//
// Ports:
//   clk        in   1            clock
//   rst_n      in   1            asynchronous active-low reset
//   in_data    in   DATA_W       PE word
//   in_dest    in   clog2(leaves) destination leaf address for in_data
//   in_valid   in   1            PE word valid
//   in_ready   out  1            packetizer can accept a word
//   pkt_o      out  p_sz         {valid, addr, payload} to interface pe_interface
//   resend     in   1            interface FIFO full, hold the current flit
//   busy       out  1            word held, flits outstanding
//   stall_cnt  out  16           (PKTZ_STALL_CNT_EN only) saturating count of
//                                cycles spent in SEND with resend high
//
// Optional feature macro: PKTZ_STALL_CNT_EN
// -----------------------------------------------------------------------------
module pe_packetizer #(
    parameter int num_leaves = 2,
    parameter int payload_sz = 1,
    parameter int NUM_FLITS  = 4,
    parameter int DATA_W     = payload_sz * NUM_FLITS,
    parameter int p_sz       = 1 + $clog2(num_leaves) + payload_sz
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_W-1:0]             in_data,
    input  logic [$clog2(num_leaves)-1:0] in_dest,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [p_sz-1:0]               pkt_o,
    input  logic                          resend,
    output logic                          busy
`ifdef PKTZ_STALL_CNT_EN
    ,
    output logic [15:0]                   stall_cnt
`endif
);

    localparam int ADDR_W = $clog2(num_leaves);
    localparam int IDX_W  = (NUM_FLITS > 1) ? $clog2(NUM_FLITS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                  state_r;
    logic [DATA_W-1:0]       word_r;
    logic [ADDR_W-1:0]       dest_r;
    logic [IDX_W-1:0]        flit_idx_r;
    logic                    in_ready_r;
    logic                    busy_r;
    logic [payload_sz-1:0]   slice_s;
    logic                    last_flit_s;

    assign last_flit_s = (flit_idx_r == IDX_W'(NUM_FLITS - 1));
    assign in_ready    = in_ready_r;
    assign busy        = busy_r;

    // Control FSM: word capture, flit stepping under backpressure, registered ready/busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            word_r     <= '0;
            dest_r     <= '0;
            flit_idx_r <= '0;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    // in_ready_r gates the accept so the first edge after
                    // reset release (where in_ready is still low) takes nothing.
                    if (in_valid && in_ready_r) begin
                        word_r     <= in_data;
                        dest_r     <= in_dest;
                        flit_idx_r <= '0;
                        state_r    <= SEND;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end else begin
                        in_ready_r <= 1'b1;
                        busy_r     <= 1'b0;
                    end
                end
                SEND: begin
                    if (!resend) begin
                        if (last_flit_s) begin
                            flit_idx_r <= '0;
                            state_r    <= IDLE;
                            in_ready_r <= 1'b1;
                            busy_r     <= 1'b0;
                        end else begin
                            flit_idx_r <= flit_idx_r + IDX_W'(1);
                        end
                    end else begin
                        // FIFO full: hold the current flit
                        flit_idx_r <= flit_idx_r;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    flit_idx_r <= '0;
                    in_ready_r <= 1'b1;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    // Payload slice select: AND-OR mux over the flit slices of the held word.
    always_comb begin
        slice_s = '0;
        for (int i = 0; i < NUM_FLITS; i++) begin
            slice_s = slice_s |
                      (word_r[i*payload_sz +: payload_sz] &
                       {payload_sz{(32'(flit_idx_r) == i)}});
        end
    end

    // Packet output: combinational so resend blanks the flit within the same cycle.
    always_comb begin
        if ((state_r == SEND) && !resend) begin
            pkt_o = {1'b1, dest_r, slice_s};
        end else begin
            pkt_o = '0;
        end
    end

`ifdef PKTZ_STALL_CNT_EN
    logic [15:0] stall_cnt_r;

    assign stall_cnt = stall_cnt_r;

    // Stall counter: cycles held in SEND by resend, saturating at all ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= 16'd0;
        end else if ((state_r == SEND) && resend && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end
`endif

endmodule

// File: tb/tb_pe_packetizer.sv
// -----------------------------------------------------------------------------
// tb_pe_packetizer
//
// Self-checking bench for pe_packetizer. Main instance uses num_leaves=4,
// payload_sz=8, NUM_FLITS=4; a second instance uses NUM_FLITS=1. The main
// instance is compared every cycle against a queue-of-expected-packets model:
// an accepted word pushes its NUM_FLITS packets, and each resend-low cycle
// with a non-empty queue pops one. Directed sections pin the model with
// hand-computed packet values.
// -----------------------------------------------------------------------------
module tb_pe_packetizer;

    localparam int NL = 4;
    localparam int PS = 8;
    localparam int NF = 4;
    localparam int AW = 2;
    localparam int DW = PS * NF;
    localparam int P  = 1 + AW + PS;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] in_data;
    logic [AW-1:0] in_dest;
    logic          in_valid;
    logic          in_ready;
    logic [P-1:0]  pkt_o;
    logic          resend;
    logic          busy;

    logic [PS-1:0] in_data1;
    logic [AW-1:0] in_dest1;
    logic          in_valid1;
    logic          in_ready1;
    logic [P-1:0]  pkt_o1;
    logic          resend1;
    logic          busy1;

`ifdef PKTZ_STALL_CNT_EN
    logic [15:0]   stall_cnt;
    logic [15:0]   stall_cnt1;
`endif

    int n_checks;
    int n_errors;

    pe_packetizer #(.num_leaves(NL), .payload_sz(PS), .NUM_FLITS(NF)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_dest  (in_dest),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .pkt_o    (pkt_o),
        .resend   (resend),
        .busy     (busy)
`ifdef PKTZ_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    pe_packetizer #(.num_leaves(NL), .payload_sz(PS), .NUM_FLITS(1)) dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data1),
        .in_dest  (in_dest1),
        .in_valid (in_valid1),
        .in_ready (in_ready1),
        .pkt_o    (pkt_o1),
        .resend   (resend1),
        .busy     (busy1)
`ifdef PKTZ_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (main instance) ----------------
    logic [P-1:0] exp_q[$];
    bit           m_rdy;
    int           m_stall;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            m_rdy   = 1'b0;
            m_stall = 0;
        end else if (exp_q.size() > 0) begin
            if (!resend) void'(exp_q.pop_front());
            else if (m_stall < 65535) m_stall++;
        end else begin
            if (m_rdy && in_valid) begin
                for (int i = 0; i < NF; i++)
                    exp_q.push_back({1'b1, in_dest, in_data[i*PS +: PS]});
            end
            m_rdy = 1'b1;
        end
    end

    // Every-cycle compare of the main instance against the model.
    always @(negedge clk) begin
        logic [P-1:0] e_pkt;
        e_pkt = (rst_n && exp_q.size() > 0 && !resend) ? exp_q[0] : '0;
        chk("cmp_pkt", 32'(pkt_o), 32'(e_pkt));
        chk("cmp_ready", 32'(in_ready), 32'(rst_n && m_rdy && exp_q.size() == 0));
        chk("cmp_busy", 32'(busy), 32'(exp_q.size() > 0));
`ifdef PKTZ_STALL_CNT_EN
        chk("cmp_stall", 32'(stall_cnt), 32'(m_stall));
`endif
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [P-1:0] w1 [4];
    logic [P-1:0] b2b [9];

    initial begin
        n_checks = 0;
        n_errors = 0;
        w1  = '{11'h6AA, 11'h6BB, 11'h6CC, 11'h6DD};
        b2b = '{11'h511, 11'h522, 11'h533, 11'h544, 11'h000,
                11'h755, 11'h766, 11'h777, 11'h788};
        rst_n = 1'b0; in_data = '0; in_dest = '0; in_valid = 1'b0; resend = 1'b0;
        in_data1 = '0; in_dest1 = '0; in_valid1 = 1'b0; resend1 = 1'b0;

        // reset state
        #3;
        chk("rst_pkt", 32'(pkt_o), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        cyc(); cyc();
        rst_n = 1'b1;

        // T1: basic word, no stalls
        cyc(); in_valid = 1'b1; in_data = 32'hDDCCBBAA; in_dest = 2'd2;
        @(negedge clk); chk("t1_ready_idle", 32'(in_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            cyc(); in_valid = 1'b0;
            @(negedge clk);
            chk("t1_flit", 32'(pkt_o), 32'(w1[i]));
            chk("t1_ready_send", 32'(in_ready), 32'd0);
        end
        cyc(); @(negedge clk);
        chk("t1_idle_pkt", 32'(pkt_o), 32'd0);
        chk("t1_ready_after", 32'(in_ready), 32'd1);

        // T2: resend high for 3 cycles during the 2nd flit
        cyc(); in_valid = 1'b1;
        cyc(); in_valid = 1'b0; @(negedge clk); chk("t2_flit0", 32'(pkt_o), 32'(w1[0]));
        for (int i = 0; i < 3; i++) begin
            cyc(); resend = 1'b1; @(negedge clk);
            chk("t2_stall_pkt", 32'(pkt_o), 32'd0);
            chk("t2_stall_busy", 32'(busy), 32'd1);
        end
        for (int i = 1; i < 4; i++) begin
            cyc(); resend = 1'b0; @(negedge clk);
            chk("t2_flit", 32'(pkt_o), 32'(w1[i]));
        end
        cyc(); @(negedge clk);
        chk("t2_idle_ready", 32'(in_ready), 32'd1);
`ifdef PKTZ_STALL_CNT_EN
        chk("t2_stall_cnt", 32'(stall_cnt), 32'd3);
`endif

        // T3: back-to-back words with in_valid held high
        cyc(); in_valid = 1'b1; in_data = 32'h44332211; in_dest = 2'd1;
        for (int i = 0; i < 9; i++) begin
            cyc();
            if (i == 4) begin in_data = 32'h88776655; in_dest = 2'd3; end
            if (i == 5) in_valid = 1'b0;
            @(negedge clk);
            chk("t3_flit", 32'(pkt_o), 32'(b2b[i]));
            if (i == 4) chk("t3_gap_ready", 32'(in_ready), 32'd1);
        end
        cyc(); @(negedge clk);

        // T4: asynchronous reset after the 2nd flit
        cyc(); in_valid = 1'b1; in_data = 32'hDDCCBBAA; in_dest = 2'd2;
        cyc(); in_valid = 1'b0; @(negedge clk); chk("t4_flit0", 32'(pkt_o), 32'(w1[0]));
        cyc(); @(negedge clk); chk("t4_flit1", 32'(pkt_o), 32'(w1[1]));
        #2 rst_n = 1'b0;
        #1;
        chk("t4_async_pkt", 32'(pkt_o), 32'd0);
        chk("t4_async_busy", 32'(busy), 32'd0);
        chk("t4_async_ready", 32'(in_ready), 32'd0);
        cyc(); cyc(); rst_n = 1'b1;
        cyc(); @(negedge clk);
        chk("t4_rel_ready", 32'(in_ready), 32'd1);
        chk("t4_rel_busy", 32'(busy), 32'd0);
        chk("t4_rel_pkt", 32'(pkt_o), 32'd0);
        cyc(); @(negedge clk); chk("t4_no_old_flit", 32'(pkt_o), 32'd0);

        // T5: NUM_FLITS=1 instance
        cyc(); in_valid1 = 1'b1; in_data1 = 8'h5A; in_dest1 = 2'd1;
        @(negedge clk); chk("t5_ready_idle", 32'(in_ready1), 32'd1);
        cyc(); in_valid1 = 1'b0; @(negedge clk);
        chk("t5_flit", 32'(pkt_o1), 32'h55A);
        chk("t5_busy", 32'(busy1), 32'd1);
        cyc(); @(negedge clk);
        chk("t5_after_pkt", 32'(pkt_o1), 32'd0);
        chk("t5_after_ready", 32'(in_ready1), 32'd1);

        // T6: resend alternating every cycle
        cyc(); in_valid = 1'b1; in_data = 32'hDDCCBBAA; in_dest = 2'd2;
        for (int i = 0; i < 8; i++) begin
            cyc(); in_valid = 1'b0; resend = (i % 2 == 0);
            @(negedge clk);
            if (i % 2 == 0) chk("t6_blank", 32'(pkt_o), 32'd0);
            else            chk("t6_flit", 32'(pkt_o), 32'(w1[i/2]));
        end
        cyc(); resend = 1'b0; @(negedge clk);
        chk("t6_done_ready", 32'(in_ready), 32'd1);
        chk("t6_done_pkt", 32'(pkt_o), 32'd0);

        // Random phase, checked by the model every cycle
        for (int c = 0; c < 4000; c++) begin
            cyc();
            rst_n    = ($urandom_range(0, 599) != 0);
            in_valid = ($urandom_range(0, 2) != 0);
            in_data  = $urandom();
            in_dest  = AW'($urandom_range(0, NL - 1));
            resend   = ($urandom_range(0, 3) == 0);
        end
        cyc(); rst_n = 1'b1; in_valid = 1'b0; resend = 1'b0;
        repeat (10) cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
